lpddr2_mpfe_guard: RTL

LPDDR2_MPFE_GUARD -- requirements
Module: lpddr2_mpfe_guard

---
 rtl/lpddr2_mpfe_guard.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/lpddr2_mpfe_guard.sv
`default_nettype none
// ============================================================================
// Module  : lpddr2_mpfe_guard
// Brief   : Avalon-MM guard between an upstream master and the LPDDR2 MPFE.
//           It holds traffic until calibration is done and bounds outstanding
//           reads. A watchdog aborts lost reads by returning FILL data.
// Revision: 1.0
// ============================================================================
module lpddr2_mpfe_guard #(
    parameter int              AW      = 25,
    parameter int              DW      = 32,
    parameter int              MAX_OUT = 8,
    parameter int              TIMEOUT = 1024,
    parameter logic [DW-1:0]   FILL    = 32'hDEADBEEF
) (
    input  logic                       avm_clk,
    input  logic                       rst_n,
    input  logic                       mpfe_reset_n,
    input  logic                       local_cal_success,
    input  logic [AW-1:0]              s_address,
    input  logic [DW-1:0]              s_writedata,
    input  logic [DW/8-1:0]            s_byteenable,
    input  logic                       s_read,
    input  logic                       s_write,
    output logic                       s_waitrequest,
    output logic [DW-1:0]              s_readdata,
    output logic                       s_readdatavalid,
    output logic [AW-1:0]              m_address,
    output logic [DW-1:0]              m_writedata,
    output logic [DW/8-1:0]            m_byteenable,
    output logic                       m_read,
    output logic                       m_write,
    input  logic                       m_waitrequest,
    input  logic [DW-1:0]              m_readdata,
    input  logic                       m_readdatavalid,
    output logic                       st_ready,
    output logic                       st_timeout,
    output logic [$clog2(MAX_OUT):0]   st_outstanding
);

    localparam int            c_ow       = $clog2(MAX_OUT) + 1;
    localparam int            c_ww       = $clog2(TIMEOUT + 1);
    localparam logic [c_ow-1:0] c_max_out  = c_ow'(MAX_OUT);
    localparam logic [c_ww-1:0] c_wd_limit = c_ww'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_WAIT_CAL = 2'd0,
        S_READY    = 2'd1,
        S_DRAIN    = 2'd2,
        S_FAULT    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_cal_meta;
    logic              r_cal_sync;
    logic [c_ow-1:0]   r_outstanding;
    logic [c_ww-1:0]   r_wd;
    logic              w_mem_ok;
    logic              w_full;
    logic              w_empty;
    logic              w_wd_expired;
    logic              w_accept;
    logic              w_ret;
    logic              w_dec;
    logic              w_wd_active;

    assign w_mem_ok     = mpfe_reset_n & r_cal_sync;
    assign w_full       = (r_outstanding == c_max_out);
    assign w_empty      = (r_outstanding == '0);
    assign w_wd_expired = (r_wd == c_wd_limit);
    assign w_wd_active  = (r_state == S_READY) || (r_state == S_DRAIN);
    assign w_dec        = w_ret & ~w_empty;

    assign m_address      = s_address;
    assign m_writedata    = s_writedata;
    assign m_byteenable   = s_byteenable;
    assign st_outstanding = r_outstanding;

    always_ff @(posedge avm_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cal_meta <= 1'b0;
            r_cal_sync <= 1'b0;
        end else begin
            r_cal_meta <= local_cal_success;
            r_cal_sync <= r_cal_meta;
        end
    end

    always_ff @(posedge avm_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT_CAL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        s_waitrequest   = 1'b1;
        s_readdata      = m_readdata;
        s_readdatavalid = 1'b0;
        m_read          = 1'b0;
        m_write         = 1'b0;
        st_ready        = 1'b0;
        w_accept        = 1'b0;
        w_ret           = 1'b0;
        case (r_state)
            S_WAIT_CAL: begin
                if (w_mem_ok) w_next = S_READY;
            end
            S_READY: begin
                st_ready        = 1'b1;
                s_waitrequest   = m_waitrequest | w_full;
                m_read          = s_read & ~w_full;
                m_write         = s_write & ~w_full;
                s_readdatavalid = m_readdatavalid;
                w_accept        = s_read & ~(m_waitrequest | w_full);
                w_ret           = m_readdatavalid;
                if (w_wd_expired)   w_next = S_FAULT;
                else if (!w_mem_ok) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                s_readdatavalid = m_readdatavalid;
                w_ret           = m_readdatavalid;
                if (w_wd_expired) w_next = S_FAULT;
                else if (w_empty) w_next = S_WAIT_CAL;
            end
            S_FAULT: begin
                // Real responses are discarded; each lost read gets one FILL beat.
                s_readdata      = FILL;
                s_readdatavalid = ~w_empty;
                w_ret           = ~w_empty;
                if (w_empty) w_next = S_WAIT_CAL;
            end
            default: w_next = S_WAIT_CAL;
        endcase
    end

    always_ff @(posedge avm_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else if (w_accept && !w_dec) begin
            r_outstanding <= r_outstanding + c_ow'(1);
        end else if (w_dec && !w_accept) begin
            r_outstanding <= r_outstanding - c_ow'(1);
        end
    end

    // Only pending reads arm the watchdog, so write-only traffic never trips it.
    always_ff @(posedge avm_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd       <= '0;
            st_timeout <= 1'b0;
        end else begin
            if (!w_wd_active || w_empty || m_readdatavalid) begin
                r_wd <= '0;
            end else if (!w_wd_expired) begin
                r_wd <= r_wd + c_ww'(1);
            end
            if (w_wd_active && w_wd_expired) begin
                st_timeout <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
